// File: rtl/ram_op_sequencer.sv
// Command sequencer for the 16x4 operand RAM: runs mem[dst] = mem[src1] op mem[src2]
// through the RAM's registered read ports, and provides a one-cycle direct load path.
module ram_op_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] opcode,
   input  logic [3:0] src1,
   input  logic [3:0] src2,
   input  logic [3:0] dst,
   input  logic       load,
   input  logic [3:0] ldaddr,
   input  logic [3:0] lddata,
   output logic       we,
   output logic [3:0] addr,
   output logic [3:0] data,
   output logic [3:0] addrop1,
   output logic [3:0] addrop2,
   input  logic [3:0] rdataop1,
   input  logic [3:0] rdataop2,
   output logic       busy,
   output logic       done,
   output logic [3:0] result,
   output logic       carry,
   output logic       zero
);

   typedef enum logic [2:0] {IDLE, LOAD, READ, EXEC, WRITE, DONE} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} op_t;

   state_t     state;
   op_t        op;
   logic [3:0] d;
   logic [4:0] alu;

   // Bit 4 is the ADD carry, and for SUB the wrap-around borrow (a < b).
   always_comb begin
      alu = 5'd0;
      case (op)
         OP_ADD: alu = {1'b0, rdataop1} + {1'b0, rdataop2};
         OP_SUB: alu = {1'b0, rdataop1} - {1'b0, rdataop2};
         OP_AND: alu = {1'b0, rdataop1 & rdataop2};
         OP_XOR: alu = {1'b0, rdataop1 ^ rdataop2};
         default: alu = 5'd0;
      endcase
   end

   // Outputs are registered on the transition into each state. addr/data also serve
   // as the load latches and addrop1/addrop2 as the source latches, because each one
   // holds exactly the value the corresponding latch would hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         op      <= OP_ADD;
         d       <= 4'd0;
         we      <= 1'b0;
         addr    <= 4'd0;
         data    <= 4'd0;
         addrop1 <= 4'd0;
         addrop2 <= 4'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= 4'd0;
         carry   <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  addr  <= ldaddr;
                  data  <= lddata;
                  we    <= 1'b1;
                  busy  <= 1'b1;
                  state <= LOAD;
               end else if (start) begin
                  op      <= op_t'(opcode);
                  d       <= dst;
                  addrop1 <= src1;
                  addrop2 <= src2;
                  busy    <= 1'b1;
                  state   <= READ;
               end
            end
            LOAD: begin
               we    <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            READ: state <= EXEC;
            EXEC: begin
               result <= alu[3:0];
               carry  <= alu[4];
               zero   <= (alu[3:0] == 4'd0);
               we     <= 1'b1;
               addr   <= d;
               data   <= alu[3:0];
               state  <= WRITE;
            end
            WRITE: begin
               we    <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_op_sequencer.sv
// Directed bench for ram_op_sequencer with a behavioural 16x4 RAM (registered reads).
module tb_ram_op_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] opcode = 2'd0;
   logic [3:0] src1 = 4'd0, src2 = 4'd0, dst = 4'd0;
   logic       load = 1'b0;
   logic [3:0] ldaddr = 4'd0, lddata = 4'd0;
   logic       we;
   logic [3:0] addr, data, addrop1, addrop2;
   logic [3:0] rdataop1, rdataop2;
   logic       busy, done, carry, zero;
   logic [3:0] result;

   logic [3:0] mem [16];
   int n_chk = 0;
   int n_pass = 0;

   localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, AND = 2'd2, XOR = 2'd3;

   ram_op_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .opcode(opcode),
      .src1(src1), .src2(src2), .dst(dst), .load(load),
      .ldaddr(ldaddr), .lddata(lddata), .we(we), .addr(addr), .data(data),
      .addrop1(addrop1), .addrop2(addrop2), .rdataop1(rdataop1), .rdataop2(rdataop2),
      .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (we) mem[addr] <= data;
      rdataop1 <= mem[addrop1];
      rdataop2 <= mem[addrop2];
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [3:0] a, input logic [3:0] v);
      load = 1'b1; ldaddr = a; lddata = v;
      step();
      load = 1'b0;
      chk("load_we", {7'd0, we}, 8'd1);
      chk("load_addr", {4'd0, addr}, {4'd0, a});
      step();
      chk("load_idle", {7'd0, busy}, 8'd0);
      chk("load_mem", {4'd0, mem[a]}, {4'd0, v});
   endtask

   task automatic do_op(input logic [1:0] o, input logic [3:0] dd, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] er, input logic ec, input logic ez);
      start = 1'b1; opcode = o; dst = dd; src1 = s1; src2 = s2;
      step();                                   // READ
      start = 1'b0;
      chk("read_busy", {7'd0, busy}, 8'd1);
      chk("read_we", {7'd0, we}, 8'd0);
      chk("read_addrop", {addrop1, addrop2}, {s1, s2});
      step();                                   // EXEC
      chk("exec_done", {7'd0, done}, 8'd0);
      step();                                   // WRITE
      chk("write_bus", {3'd0, we, addr}, {3'd0, 1'b1, dd});
      chk("write_data", {4'd0, data}, {4'd0, er});
      step();                                   // DONE
      chk("done_pulse", {6'd0, done, busy}, 8'b11);
      chk("op_result", {2'd0, carry, zero, result}, {2'd0, ec, ez, er});
      chk("done_we", {7'd0, we}, 8'd0);
      step();                                   // IDLE
      chk("idle_after", {6'd0, done, busy}, 8'd0);
      chk("op_mem", {4'd0, mem[dd]}, {4'd0, er});
   endtask

   initial begin
      step(); step();
      reset = 1'b0;
      chk("rst_ctl", {4'd0, we, busy, done, carry}, 8'd0);
      chk("rst_zero_res", {3'd0, zero, result}, 8'd0);
      chk("rst_addr", {addr, data}, 8'd0);
      chk("rst_addrop", {addrop1, addrop2}, 8'd0);

      // ADD without carry
      do_load(4'd1, 4'd3);
      do_load(4'd2, 4'd5);
      do_op(ADD, 4'd4, 4'd1, 4'd2, 4'd8, 1'b0, 1'b0);

      // ADD with carry, SUB to zero
      do_load(4'd0, 4'd9);
      do_load(4'd3, 4'd9);
      do_op(ADD, 4'd5, 4'd0, 4'd3, 4'd2, 1'b1, 1'b0);
      do_op(SUB, 4'd6, 4'd0, 4'd3, 4'd0, 1'b0, 1'b1);

      // SUB with borrow, destination overlaps src1
      do_op(SUB, 4'd1, 4'd1, 4'd2, 4'd14, 1'b1, 1'b0);
      chk("src2_kept", {4'd0, mem[2]}, 8'd5);

      // AND with src1==src2, then XOR
      do_load(4'd7, 4'd12);
      do_load(4'd8, 4'd10);
      do_op(AND, 4'd9, 4'd7, 4'd7, 4'd12, 1'b0, 1'b0);
      do_op(XOR, 4'd10, 4'd7, 4'd8, 4'd6, 1'b0, 1'b0);

      // start held through READ/EXEC/WRITE is ignored
      do_load(4'd14, 4'd0);
      do_load(4'd15, 4'd0);
      start = 1'b1; opcode = ADD; dst = 4'd14; src1 = 4'd2; src2 = 4'd2;
      step();
      opcode = XOR; dst = 4'd15; src1 = 4'd1; src2 = 4'd2;
      step(); step();
      chk("spur_write_addr", {4'd0, addr}, 8'd14);
      step();
      start = 1'b0;
      chk("spur_done", {7'd0, done}, 8'd1);
      chk("spur_result", {4'd0, result}, 8'd10);
      step();
      chk("spur_idle", {7'd0, busy}, 8'd0);
      step();
      chk("spur_still_idle", {7'd0, busy}, 8'd0);
      chk("spur_mem14", {4'd0, mem[14]}, 8'd10);
      chk("spur_mem15", {4'd0, mem[15]}, 8'd0);

      // load and start together: load wins, start dropped
      load = 1'b1; ldaddr = 4'd11; lddata = 4'd4;
      start = 1'b1; opcode = ADD; dst = 4'd15; src1 = 4'd1; src2 = 4'd2;
      step();
      load = 1'b0; start = 1'b0;
      chk("ls_load_bus", {3'd0, we, addr}, {3'd0, 1'b1, 4'd11});
      chk("ls_load_data", {4'd0, data}, 8'd4);
      step();
      chk("ls_idle", {7'd0, busy}, 8'd0);
      chk("ls_mem11", {4'd0, mem[11]}, 8'd4);
      step();
      chk("ls_no_start", {6'd0, busy, we}, 8'd0);
      chk("ls_mem15", {4'd0, mem[15]}, 8'd0);

      // reset during EXEC: no write
      do_load(4'd12, 4'd1);
      start = 1'b1; opcode = ADD; dst = 4'd12; src1 = 4'd1; src2 = 4'd2;
      step();                                   // READ
      start = 1'b0;
      step();                                   // EXEC
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rexec_ctl", {5'd0, we, busy, done}, 8'd0);
      chk("rexec_res", {2'd0, carry, zero, result}, 8'd0);
      step(); step();
      chk("rexec_mem12", {4'd0, mem[12]}, 8'd1);
      chk("rexec_idle", {7'd0, busy}, 8'd0);

      // reset during WRITE: write still commits (14+5 -> 3)
      do_load(4'd13, 4'd0);
      start = 1'b1; opcode = ADD; dst = 4'd13; src1 = 4'd1; src2 = 4'd2;
      step();
      start = 1'b0;
      step(); step();                           // WRITE
      chk("rwr_we", {7'd0, we}, 8'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rwr_mem13", {4'd0, mem[13]}, 8'd3);
      chk("rwr_ctl", {5'd0, we, busy, done}, 8'd0);
      chk("rwr_res", {2'd0, carry, zero, result}, 8'd0);
      chk("rwr_addr", {addr, data}, 8'd0);
      chk("rwr_addrop", {addrop1, addrop2}, 8'd0);
      step();
      chk("rwr_idle", {6'd0, busy, done}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
